// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-read stage, the RV32M
// multiply/divide unit and the register-file write port.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             reg_write_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, reg_write_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out, reg_write_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle. Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           f3_q, f3_d;
    logic [4:0]           rd_q, rd_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [4:0]           rd_out_q, rd_out_d;
    logic                 busy_q, done_q, wr_q;

    logic                 a_signed_s, b_signed_s;
    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
`ifdef MULDIV_DIV_EN
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH:0]       div_top_s;
    logic [WIDTH+1:0]     div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [WIDTH-1:0]     quo_fix_s, rem_fix_s;
    logic                 ovf_s;
`endif

    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic neg);
        mag_f = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand signedness per funct3, evaluated on the live request for capture.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (bus.funct3)
            3'b001:         begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010:         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        a_neg_s = a_signed_s & bus.op_a[WIDTH-1];
        b_neg_s = b_signed_s & bus.op_b[WIDTH-1];
        a_mag_s = mag_f(bus.op_a, a_neg_s);
        b_mag_s = mag_f(bus.op_b, b_neg_s);
    end

    // Datapath steps: one multiply/divide iteration plus sign fix-up of the final values.
    always_comb begin
        mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, prod_q[WIDTH-1:1]};
        prod_fix_s = neg_q ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;
`ifdef MULDIV_DIV_EN
        // Low half holds the dividend shifting out / quotient shifting in; high half the remainder.
        div_top_s  = prod_q[2*WIDTH-1:WIDTH-1];
        div_diff_s = {1'b0, div_top_s} - {2'b00, opnd_q};
        if (div_diff_s[WIDTH+1]) begin
            div_next_s = {prod_q[2*WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end
        quo_fix_s = mag_f(prod_q[WIDTH-1:0], neg_q);
        rem_fix_s = mag_f(prod_q[2*WIDTH-1:WIDTH], neg_rem_q);
        ovf_s     = ~bus.funct3[0] &&
                    (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (bus.op_b == {WIDTH{1'b1}});
`endif
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
`ifdef MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    f3_d  = bus.funct3;
                    rd_d  = bus.rd_in;
                    cnt_d = {CW{1'b0}};
                    neg_d = a_neg_s ^ b_neg_s;
                    if (bus.funct3[2]) begin
`ifdef MULDIV_DIV_EN
                        opnd_d    = b_mag_s;
                        prod_d    = {{WIDTH{1'b0}}, a_mag_s};
                        neg_rem_d = a_neg_s;
                        if (bus.op_b == {WIDTH{1'b0}}) begin
                            state_d  = S_DONE;
                            result_d = bus.funct3[1] ? bus.op_a : {WIDTH{1'b1}};
                            rd_out_d = bus.rd_in;
                        end else if (ovf_s) begin
                            state_d  = S_DONE;
                            result_d = bus.funct3[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
                            rd_out_d = bus.rd_in;
                        end else begin
                            state_d  = S_CALC;
                        end
`else
                        state_d  = S_DONE;
                        result_d = {WIDTH{1'b0}};
                        rd_out_d = bus.rd_in;
`endif
                    end else begin
                        opnd_d  = a_mag_s;
                        prod_d  = {{WIDTH{1'b0}}, b_mag_s};
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
`ifdef MULDIV_DIV_EN
                prod_d = f3_q[2] ? div_next_s : mul_next_s;
`else
                prod_d = mul_next_s;
`endif
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                case (f3_q)
                    3'b000:                 result_d = prod_fix_s[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
                    3'b100, 3'b101:         result_d = quo_fix_s;
                    3'b110, 3'b111:         result_d = rem_fix_s;
`endif
                    default:                result_d = {WIDTH{1'b0}};
                endcase
                rd_out_d = rd_q;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            f3_q      <= 3'b000;
            rd_q      <= 5'd0;
            opnd_q    <= {WIDTH{1'b0}};
            prod_q    <= {(2*WIDTH){1'b0}};
            neg_q     <= 1'b0;
            result_q  <= {WIDTH{1'b0}};
            rd_out_q  <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            wr_q      <= (state_d == S_DONE) && (rd_out_d != 5'd0);
`ifdef MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.result        = result_q;
    assign bus.rd_out        = rd_out_q;
    assign bus.reg_write_out = wr_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return f3[2] && ((b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return f3[2];
`endif
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        int         ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            F_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            F_MULH:   begin p = sa * sb; return p[63:32]; end
            F_MULHSU: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            F_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
`ifdef MULDIV_DIV_EN
            F_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            F_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            F_REMU: return (b == 32'h0) ? a : a % b;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // One operation: issue, find the edge carrying done, check outputs and the following idle cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit inject);
        logic [31:0] exp_res;
        int          exp_edge;
        int          k;
        int          extra;
        exp_res  = ref_res(f3, a, b);
        exp_edge = is_special(f3, a, b) ? 0 : 33;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
        bus.rd_in = 5'($urandom);
        chk($sformatf("f3=%0d busy_after_start", f3), {31'h0, bus.busy}, 32'h1);
        k = 0;
        while (bus.done !== 1'b1 && k < 60) begin
            if (inject && k == 4) begin
                @(negedge clk);
                bus.start = 1'b1; bus.funct3 = F_MULHU; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF;
                bus.rd_in = 5'd7;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            k++;
        end
        chk($sformatf("f3=%0d done_edge", f3), k, exp_edge);
        chk($sformatf("f3=%0d result a=%h b=%h", f3, a, b), bus.result, exp_res);
        chk($sformatf("f3=%0d rd_out", f3), {27'h0, bus.rd_out}, {27'h0, rd});
        chk($sformatf("f3=%0d reg_write_out", f3), {31'h0, bus.reg_write_out}, {31'h0, rd != 5'd0});
        @(posedge clk); #1;
        chk($sformatf("f3=%0d done_pulse_end", f3), {31'h0, bus.done}, 32'h0);
        chk($sformatf("f3=%0d busy_end", f3), {31'h0, bus.busy}, 32'h0);
        chk($sformatf("f3=%0d result_held", f3), bus.result, exp_res);
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) extra++;
            end
            chk("ignored_start_extra_done", extra, 0);
            chk("ignored_start_result", bus.result, exp_res);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.op_a = 32'h0; bus.op_b = 32'h0; bus.rd_in = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_rd_out", {27'h0, bus.rd_out}, 32'h0);
        chk("reset_reg_write", {31'h0, bus.reg_write_out}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op(F_MUL,    32'd7,          32'd6,          5'd5,  1'b0);
        run_op(F_MUL,    32'd7,          32'd6,          5'd0,  1'b0);
        run_op(F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  1'b0);
        run_op(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  1'b0);
        run_op(F_MULHSU, 32'hFFFF_FFFF,  32'h0000_0002,  5'd3,  1'b0);
        run_op(F_DIV,    32'hFFFF_FFF9,  32'd2,          5'd4,  1'b0);
        run_op(F_REM,    32'hFFFF_FFF9,  32'd2,          5'd6,  1'b0);
        run_op(F_DIVU,   32'd100,        32'd7,          5'd8,  1'b0);
        run_op(F_REMU,   32'd100,        32'd7,          5'd9,  1'b0);
        run_op(F_DIVU,   32'd5,          32'd0,          5'd10, 1'b0);
        run_op(F_REMU,   32'd5,          32'd0,          5'd11, 1'b0);
        run_op(F_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 1'b0);
        run_op(F_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 1'b0);
        run_op(F_MUL,    32'h0001_2345,  32'h0000_6789,  5'd14, 1'b1);

        // Asynchronous reset ten edges into a calculation.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = F_MUL; bus.op_a = 32'h0000_1111; bus.op_b = 32'h0000_2222;
        bus.rd_in = 5'd15;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
        chk("midrst_done", {31'h0, bus.done}, 32'h0);
        chk("midrst_result", bus.result, 32'h0);
        chk("midrst_rd_out", {27'h0, bus.rd_out}, 32'h0);
        chk("midrst_reg_write", {31'h0, bus.reg_write_out}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_op(F_MUL, 32'd3, 32'd4, 5'd16, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
